engine_configure_memory_multiword: RTL and testbench

Parametrised engine configuration loader that assembles a multi-word configuration record from `CMD_MEM_PROGRAM` memory responses and queues complete records into an output FIFO for the owning engine. Words may arrive in any order; a record is released only once every word is present. The block supports reload or one-shot mode and reports protocol errors. It sits between the engine's memory-response path and the engine datapath's configuration input.

---
 rtl/engine_configure_memory_multiword_pkg.sv | 57 +++++
 rtl/engine_configure_memory_multiword_if.sv | 21 ++
 rtl/xpm_fifo_sync_wrapper.sv | 72 +++++++
 rtl/engine_configure_memory_multiword.sv | 170 +++++++++++++++++
 tb/tb_engine_configure_memory_multiword.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/engine_configure_memory_multiword_pkg.sv
// Shared types for the multi-word engine configuration loader: memory packet
// layout, FIFO status structs, loader states and the sequence-index helper.
package engine_configure_memory_multiword_pkg;

    localparam int M_AXI4_FE_ADDR_W = 32;
    localparam int SHIFT_AMOUNT_W   = 6;
    localparam int DATA_FIELD_W     = 64;

    typedef enum logic [2:0] {
        CMD_INVALID      = 3'd0,
        CMD_MEM_READ     = 3'd1,
        CMD_MEM_WRITE    = 3'd2,
        CMD_MEM_PROGRAM  = 3'd3,
        CMD_MEM_RESPONSE = 3'd4
    } command_type;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMMIT  = 2'd1,
        LOCKED  = 2'd2
    } engine_configure_memory_state;

    typedef struct packed { logic [SHIFT_AMOUNT_W-1:0] amount; } ShiftSignals;
    typedef struct packed {
        logic [M_AXI4_FE_ADDR_W-1:0] offset;
        ShiftSignals                 shift;
    } AddressSignals;
    typedef struct packed { command_type cmd; } SubclassSignals;
    typedef struct packed {
        AddressSignals  address;
        SubclassSignals subclass;
    } MetaSignals;
    typedef struct packed { logic [DATA_FIELD_W-1:0] field; } DataSignals;
    typedef struct packed {
        MetaSignals meta;
        DataSignals data;
    } PayloadSignals;
    typedef struct packed {
        logic          valid;
        PayloadSignals payload;
    } MemoryPacket;

    typedef struct packed { logic rd_en; } FIFOStateSignalsInput;
    typedef struct packed {
        logic full;
        logic empty;
        logic valid;
        logic prog_full;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutput;

    function automatic logic [M_AXI4_FE_ADDR_W-1:0] seq_index(input AddressSignals addr);
        return addr.offset >> addr.shift.amount;
    endfunction

endpackage

// File: rtl/engine_configure_memory_multiword_if.sv
// Memory-response channel into the configuration loader: packet stream,
// upstream read enable and the backpressure status returned to the source.
interface engine_configure_memory_multiword_if;
    import engine_configure_memory_multiword_pkg::*;

    MemoryPacket           response_memory_in;
    FIFOStateSignalsInput  fifo_response_memory_in_signals_in;
    FIFOStateSignalsOutput fifo_response_memory_in_signals_out;

    modport master (
        output response_memory_in,
        output fifo_response_memory_in_signals_in,
        input  fifo_response_memory_in_signals_out
    );

    modport slave (
        input  response_memory_in,
        input  fifo_response_memory_in_signals_in,
        output fifo_response_memory_in_signals_out
    );
endinterface

// File: rtl/xpm_fifo_sync_wrapper.sv
// Synchronous standard-mode FIFO (one-cycle read latency, valid flag) with a
// short reset-busy window after srst, mirroring the vendor macro's behaviour.
module xpm_fifo_sync_wrapper #(
    parameter int FIFO_WRITE_DEPTH = 16,
    parameter int WRITE_DATA_WIDTH = 32,
    parameter int PROG_FULL_THRESH = 8
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [WRITE_DATA_WIDTH-1:0] din,
    input  logic                        wr_en,
    input  logic                        rd_en,
    output logic [WRITE_DATA_WIDTH-1:0] dout,
    output logic                        full,
    output logic                        empty,
    output logic                        valid,
    output logic                        prog_full,
    output logic                        wr_rst_busy,
    output logic                        rd_rst_busy
);
    localparam int PTR_W = (FIFO_WRITE_DEPTH > 1) ? $clog2(FIFO_WRITE_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_WRITE_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_WRITE_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_WRITE_DEPTH);
    localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(PROG_FULL_THRESH);
    localparam logic [1:0]       RST_BUSY_CYCLES = 2'd3;

    logic [WRITE_DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        valid_q;
    logic [1:0]                  rst_cnt_q;
    logic [WRITE_DATA_WIDTH-1:0] dout_q;
    logic                        busy, do_wr, do_rd;

    assign busy        = (rst_cnt_q != 2'd0);
    assign full        = busy | (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign prog_full   = (count_q >= THRESH_CNT);
    assign valid       = valid_q;
    assign dout        = dout_q;
    assign wr_rst_busy = busy;
    assign rd_rst_busy = busy;
    assign do_wr       = wr_en & ~full;
    assign do_rd       = rd_en & ~empty & ~busy;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            rst_cnt_q <= RST_BUSY_CYCLES;
        end else begin
            if (busy) rst_cnt_q <= rst_cnt_q - 2'd1;
            if (do_wr) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            valid_q <= do_rd;
        end
    end

    // Storage and read data carry no reset; valid qualifies dout.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
        if (do_rd) dout_q <= mem[rd_ptr_q];
    end
endmodule

// File: rtl/engine_configure_memory_multiword.sv
// Assembles NUM_WORDS configuration words arriving in any order from
// CMD_MEM_PROGRAM responses and queues each complete record for the engine.
module engine_configure_memory_multiword
    import engine_configure_memory_multiword_pkg::*;
#(
    parameter int ID_CU            = 0,
    parameter int ID_BUNDLE        = 0,
    parameter int ID_LANE          = 0,
    parameter int ID_ENGINE        = 0,
    parameter int ID_MODULE        = 0,
    parameter int ID_RELATIVE      = 0,
    parameter int NUM_WORDS        = 16,
    parameter int CFG_DATA_W       = 32,
    parameter int SEQ_MIN          = ID_RELATIVE * NUM_WORDS,
    parameter int FIFO_WRITE_DEPTH = 16,
    parameter int PROG_THRESH      = 8,
    parameter int ONE_SHOT         = 0
) (
    input  logic                                ap_clk,
    input  logic                                areset,
    engine_configure_memory_multiword_if.slave  response_memory_if,
    output logic                                configure_memory_out_valid,
    output logic [NUM_WORDS*CFG_DATA_W-1:0]     configure_memory_out_payload,
    input  FIFOStateSignalsInput                fifo_configure_memory_signals_in,
    output FIFOStateSignalsOutput               fifo_configure_memory_signals_out,
    output logic                                fifo_setup_signal,
    output logic                                configure_error_out
);
    localparam int REC_W = NUM_WORDS * CFG_DATA_W;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [M_AXI4_FE_ADDR_W-1:0] SEQ_LO = M_AXI4_FE_ADDR_W'(SEQ_MIN);
    localparam logic [M_AXI4_FE_ADDR_W-1:0] SEQ_HI = M_AXI4_FE_ADDR_W'(SEQ_MIN + NUM_WORDS);
    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_COMMIT  = COMMIT;
    localparam logic [1:0] ST_LOCKED  = LOCKED;
    localparam int unused_id_sum = ID_CU + ID_BUNDLE + ID_LANE + ID_ENGINE + ID_MODULE;

    logic                        rst_ctrl_q, rst_fifo_q;
    MemoryPacket                 packet_q;
    FIFOStateSignalsInput        unused_upstream_q;
    logic                        rd_en_q;
    logic [1:0]                  state_q, state_d;
    logic [NUM_WORDS-1:0]        recv_mask_q, recv_mask_d;
    logic                        error_q, error_d;
    logic [REC_W-1:0]            words_q;
    logic                        out_valid_q;
    logic [REC_W-1:0]            out_payload_q;
    logic                        pkt_match, word_we, fifo_wr_en, fifo_rd_en;
    logic [M_AXI4_FE_ADDR_W-1:0] seq, seq_rel;
    logic [IDX_W-1:0]            idx;
    logic [REC_W-1:0]            fifo_dout;
    logic                        f_full, f_empty, f_valid, f_prog_full, f_wr_busy, f_rd_busy;
    FIFOStateSignalsOutput       fifo_status;
    logic                        unused_bits;

    // Reset is retimed once, with separate copies for control and FIFO.
    always_ff @(posedge ap_clk) begin
        rst_ctrl_q <= areset;
        rst_fifo_q <= areset;
    end

    always_ff @(posedge ap_clk) begin
        if (rst_ctrl_q) begin
            packet_q          <= '0;
            unused_upstream_q <= '0;
            rd_en_q           <= 1'b0;
        end else begin
            packet_q          <= response_memory_if.response_memory_in;
            unused_upstream_q <= response_memory_if.fifo_response_memory_in_signals_in;
            rd_en_q           <= fifo_configure_memory_signals_in.rd_en;
        end
    end

    assign seq       = seq_index(packet_q.payload.meta.address);
    assign seq_rel   = seq - SEQ_LO;
    assign idx       = seq_rel[IDX_W-1:0];
    assign pkt_match = packet_q.valid
                     & (packet_q.payload.meta.subclass.cmd == CMD_MEM_PROGRAM)
                     & (seq >= SEQ_LO) & (seq < SEQ_HI);
    assign unused_bits = ^{packet_q, seq_rel};

    always_comb begin
        state_d     = state_q;
        recv_mask_d = recv_mask_q;
        error_d     = error_q;
        word_we     = 1'b0;
        fifo_wr_en  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (pkt_match) begin
                    word_we = 1'b1;
                    if (recv_mask_q[idx]) error_d = 1'b1;
                    recv_mask_d[idx] = 1'b1;
                    if (&recv_mask_d) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Words arriving while a record waits for FIFO space are lost.
                if (pkt_match) error_d = 1'b1;
                if (!f_full) begin
                    fifo_wr_en  = 1'b1;
                    recv_mask_d = '0;
                    state_d     = (ONE_SHOT != 0) ? ST_LOCKED : ST_COLLECT;
                end
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (rst_ctrl_q) begin
            state_q     <= ST_COLLECT;
            recv_mask_q <= '0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            recv_mask_q <= recv_mask_d;
            error_q     <= error_d;
            out_valid_q <= f_valid;
        end
    end

    // Word array and output payload are qualified by mask/valid, so no reset.
    always_ff @(posedge ap_clk) begin
        out_payload_q <= fifo_dout;
        if (word_we) words_q[idx*CFG_DATA_W +: CFG_DATA_W] <= packet_q.payload.data.field[CFG_DATA_W-1:0];
    end

    assign fifo_rd_en = rd_en_q & ~f_empty;

    xpm_fifo_sync_wrapper #(
        .FIFO_WRITE_DEPTH (FIFO_WRITE_DEPTH),
        .WRITE_DATA_WIDTH (REC_W),
        .PROG_FULL_THRESH (PROG_THRESH)
    ) u_fifo (
        .clk         (ap_clk),
        .srst        (rst_fifo_q),
        .din         (words_q),
        .wr_en       (fifo_wr_en),
        .rd_en       (fifo_rd_en),
        .dout        (fifo_dout),
        .full        (f_full),
        .empty       (f_empty),
        .valid       (f_valid),
        .prog_full   (f_prog_full),
        .wr_rst_busy (f_wr_busy),
        .rd_rst_busy (f_rd_busy)
    );

    always_comb begin
        fifo_status.full        = f_full;
        fifo_status.empty       = f_empty;
        fifo_status.valid       = f_valid;
        fifo_status.prog_full   = f_prog_full;
        fifo_status.wr_rst_busy = f_wr_busy;
        fifo_status.rd_rst_busy = f_rd_busy;
        fifo_configure_memory_signals_out = fifo_status;
        response_memory_if.fifo_response_memory_in_signals_out = fifo_status;
        // Hold the source off while a finished record is waiting to be queued.
        response_memory_if.fifo_response_memory_in_signals_out.prog_full =
            f_prog_full | (state_q == ST_COMMIT);
    end

    assign configure_memory_out_valid   = out_valid_q;
    assign configure_memory_out_payload = out_payload_q;
    assign fifo_setup_signal            = f_wr_busy | f_rd_busy;
    assign configure_error_out          = error_q;
endmodule

// File: tb/tb_engine_configure_memory_multiword.sv
// Directed plus randomized bench for the configuration loader: a reload
// instance and a one-shot instance checked against a record-level model.
module tb_engine_configure_memory_multiword;
    import engine_configure_memory_multiword_pkg::*;

    localparam int NW    = 4;
    localparam int DW    = 32;
    localparam int SEQ0  = 8;
    localparam int DEPTH = 16;
    localparam int RW    = NW * DW;

    logic ap_clk = 1'b0;
    logic areset;
    always #5 ap_clk = ~ap_clk;

    engine_configure_memory_multiword_if mif();
    engine_configure_memory_multiword_if oif();

    logic                  m_out_valid, o_out_valid;
    logic [RW-1:0]         m_out_payload, o_out_payload;
    FIFOStateSignalsInput  m_rd, o_rd;
    FIFOStateSignalsOutput m_cfg_st, o_cfg_st;
    logic                  m_setup, o_setup, m_err, o_err;

    engine_configure_memory_multiword #(
        .ID_RELATIVE(2), .NUM_WORDS(NW), .CFG_DATA_W(DW),
        .FIFO_WRITE_DEPTH(DEPTH), .PROG_THRESH(8), .ONE_SHOT(0)
    ) dut (
        .ap_clk                            (ap_clk),
        .areset                            (areset),
        .response_memory_if                (mif),
        .configure_memory_out_valid        (m_out_valid),
        .configure_memory_out_payload      (m_out_payload),
        .fifo_configure_memory_signals_in  (m_rd),
        .fifo_configure_memory_signals_out (m_cfg_st),
        .fifo_setup_signal                 (m_setup),
        .configure_error_out               (m_err)
    );

    engine_configure_memory_multiword #(
        .ID_RELATIVE(2), .NUM_WORDS(NW), .CFG_DATA_W(DW),
        .FIFO_WRITE_DEPTH(DEPTH), .PROG_THRESH(8), .ONE_SHOT(1)
    ) dut_os (
        .ap_clk                            (ap_clk),
        .areset                            (areset),
        .response_memory_if                (oif),
        .configure_memory_out_valid        (o_out_valid),
        .configure_memory_out_payload      (o_out_payload),
        .fifo_configure_memory_signals_in  (o_rd),
        .fifo_configure_memory_signals_out (o_cfg_st),
        .fifo_setup_signal                 (o_setup),
        .configure_error_out               (o_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Record-level model: instance 0 reloads, instance 1 is one-shot.
    logic [NW-1:0] md_mask [2];
    logic [DW-1:0] md_words [2][NW];
    logic          md_err [2];
    logic          md_lock [2];
    logic          md_pend [2];
    logic [RW-1:0] q0[$];
    logic [RW-1:0] q1[$];

    task automatic check_word(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic int qsize(input int inst);
        return (inst == 0) ? q0.size() : q1.size();
    endfunction

    task automatic md_push(input int inst);
        logic [RW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = md_words[inst][i];
        if (inst == 0) q0.push_back(r); else q1.push_back(r);
        md_mask[inst] = '0;
        if (inst == 1) md_lock[inst] = 1'b1;
    endtask

    task automatic md_reset();
        for (int i = 0; i < 2; i++) begin
            md_mask[i] = '0;
            md_err[i]  = 1'b0;
            md_lock[i] = 1'b0;
            md_pend[i] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic md_packet(input int inst, input int seq, input logic is_prog, input logic [DW-1:0] data);
        int idx;
        if (md_lock[inst] || !is_prog || seq < SEQ0 || seq >= SEQ0 + NW) return;
        if (md_pend[inst]) begin
            md_err[inst] = 1'b1;
            return;
        end
        idx = seq - SEQ0;
        if (md_mask[inst][idx]) md_err[inst] = 1'b1;
        md_mask[inst][idx]  = 1'b1;
        md_words[inst][idx] = data;
        if (&md_mask[inst]) begin
            if (qsize(inst) < DEPTH) md_push(inst);
            else md_pend[inst] = 1'b1;
        end
    endtask

    // One packet for one cycle, then idle; 'timed' checks commit/write latency.
    task automatic send(input int inst, input int seq, input logic is_prog,
                        input logic [DW-1:0] data, input logic timed);
        MemoryPacket p;
        int sh;
        sh = $urandom_range(3, 0);
        p = '0;
        p.valid = 1'b1;
        if (is_prog) p.payload.meta.subclass.cmd = CMD_MEM_PROGRAM;
        else if ($urandom_range(1, 0) == 0) p.payload.meta.subclass.cmd = CMD_MEM_READ;
        else p.payload.meta.subclass.cmd = CMD_MEM_WRITE;
        p.payload.meta.address.offset = (32'(seq) << sh) | ($urandom & ((32'd1 << sh) - 32'd1));
        p.payload.meta.address.shift.amount = 6'(sh);
        p.payload.data.field = {$urandom, data};
        if (inst == 0) mif.response_memory_in = p; else oif.response_memory_in = p;
        tick();
        mif.response_memory_in = '0;
        oif.response_memory_in = '0;
        if (timed) begin
            check_bit("lat_t1_prog_full", mif.fifo_response_memory_in_signals_out.prog_full, 1'b0);
            check_bit("lat_t1_empty", m_cfg_st.empty, 1'b1);
        end
        tick();
        if (timed) begin
            check_bit("lat_t2_commit", mif.fifo_response_memory_in_signals_out.prog_full, 1'b1);
            check_bit("lat_t2_empty", m_cfg_st.empty, 1'b1);
        end
        tick();
        if (timed) begin
            check_bit("lat_t3_prog_full", mif.fifo_response_memory_in_signals_out.prog_full, 1'b0);
            check_bit("lat_t3_empty", m_cfg_st.empty, 1'b0);
        end
        tick();
        md_packet(inst, seq, is_prog, data);
    endtask

    task automatic send_noise(input int inst);
        int kind;
        kind = $urandom_range(2, 0);
        case (kind)
            0:       send(inst, $urandom_range(7, 0), 1'b1, $urandom, 1'b0);
            1:       send(inst, $urandom_range(20, 12), 1'b1, $urandom, 1'b0);
            default: send(inst, SEQ0 + $urandom_range(3, 0), 1'b0, $urandom, 1'b0);
        endcase
    endtask

    task automatic pop_check(input int inst, input string tag, output logic [RW-1:0] got);
        logic [RW-1:0] exp_rec;
        logic          have;
        int            n_valid, first_c;
        have    = (qsize(inst) > 0);
        exp_rec = '0;
        if (have) begin
            if (inst == 0) exp_rec = q0.pop_front(); else exp_rec = q1.pop_front();
        end
        got     = '0;
        n_valid = 0;
        first_c = -1;
        if (inst == 0) m_rd.rd_en = 1'b1; else o_rd.rd_en = 1'b1;
        tick();
        m_rd.rd_en = 1'b0;
        o_rd.rd_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if ((inst == 0) ? m_out_valid : o_out_valid) begin
                if (n_valid == 0) begin
                    first_c = c;
                    got = (inst == 0) ? m_out_payload : o_out_payload;
                end
                n_valid++;
            end
        end
        check_int({tag, "_nvalid"}, n_valid, have ? 1 : 0);
        if (have) begin
            check_word({tag, "_payload"}, got, exp_rec);
            check_int({tag, "_latency"}, first_c, 1);
        end
        if (md_pend[inst]) begin
            md_pend[inst] = 1'b0;
            md_push(inst);
        end
    endtask

    task automatic do_reset(input string tag);
        areset = 1'b1;
        repeat (3) tick();
        check_bit({tag, "_setup_m"}, m_setup, 1'b1);
        check_bit({tag, "_setup_o"}, o_setup, 1'b1);
        check_bit({tag, "_valid_rst"}, m_out_valid, 1'b0);
        check_bit({tag, "_err_rst"}, m_err, 1'b0);
        areset = 1'b0;
        md_reset();
        repeat (8) tick();
        check_bit({tag, "_setup_done"}, m_setup, 1'b0);
        check_bit({tag, "_empty"}, m_cfg_st.empty, 1'b1);
        check_bit({tag, "_prog_full"}, mif.fifo_response_memory_in_signals_out.prog_full, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] got;
        logic [RW-1:0] lit;
        int ord[NW];
        areset = 1'b1;
        mif.response_memory_in = '0;
        mif.fifo_response_memory_in_signals_in = '0;
        oif.response_memory_in = '0;
        oif.fifo_response_memory_in_signals_in = '0;
        m_rd = '0;
        o_rd = '0;
        md_reset();
        do_reset("por");

        // In-order load with latency checks on the last word.
        lit = 128'h000000A3_000000A2_000000A1_000000A0;
        send(0, 8, 1'b1, 32'hA0, 1'b0);
        send(0, 9, 1'b1, 32'hA1, 1'b0);
        send(0, 10, 1'b1, 32'hA2, 1'b0);
        send(0, 11, 1'b1, 32'hA3, 1'b1);
        pop_check(0, "inorder", got);
        check_word("inorder_literal", got, lit);
        check_bit("inorder_err", m_err, md_err[0]);

        // Out-of-order with noise.
        send(0, 10, 1'b1, 32'hA2, 1'b0);
        send(0, 12, 1'b1, $urandom, 1'b0);
        send(0, 8, 1'b1, 32'hA0, 1'b0);
        send(0, 9, 1'b0, $urandom, 1'b0);
        send(0, 7, 1'b1, $urandom, 1'b0);
        send(0, 11, 1'b1, 32'hA3, 1'b0);
        send(0, 9, 1'b1, 32'hA1, 1'b0);
        pop_check(0, "ooo", got);
        check_word("ooo_literal", got, lit);
        check_bit("ooo_err", m_err, 1'b0);

        // Duplicate word.
        send(0, 8, 1'b1, 32'h1, 1'b0);
        send(0, 8, 1'b1, 32'h2, 1'b0);
        check_bit("dup_err_set", m_err, 1'b1);
        send(0, 9, 1'b1, 32'h9, 1'b0);
        send(0, 10, 1'b1, 32'hA, 1'b0);
        send(0, 11, 1'b1, 32'hB, 1'b0);
        pop_check(0, "dup", got);
        check_word("dup_word0", {96'd0, got[31:0]}, {96'd0, 32'h2});
        check_bit("dup_err_sticky", m_err, 1'b1);
        do_reset("rst_dup");

        // FIFO full: 16 records, then a 17th held in COMMIT.
        for (int r = 0; r < DEPTH + 1; r++) begin
            for (int w = 0; w < NW; w++) send(0, SEQ0 + w, 1'b1, $urandom, 1'b0);
        end
        check_bit("full_flag", m_cfg_st.full, 1'b1);
        check_bit("full_prog_full", mif.fifo_response_memory_in_signals_out.prog_full, 1'b1);
        check_bit("full_pending_model", md_pend[0], 1'b1);
        send(0, SEQ0, 1'b1, $urandom, 1'b0);
        check_bit("full_err", m_err, md_err[0]);
        for (int r = 0; r < DEPTH + 1; r++) pop_check(0, "drain", got);
        check_bit("drain_empty", m_cfg_st.empty, 1'b1);
        pop_check(0, "drain_extra", got);
        do_reset("rst_full");

        // One-shot: second record is ignored.
        for (int r = 0; r < 2; r++) begin
            for (int w = NW - 1; w >= 0; w--) send(1, SEQ0 + w, 1'b1, $urandom, 1'b0);
        end
        pop_check(1, "oneshot_first", got);
        pop_check(1, "oneshot_second", got);
        check_bit("oneshot_err", o_err, 1'b0);

        // Reset mid-record discards partial words.
        send(0, 8, 1'b1, 32'hDEAD0000, 1'b0);
        send(0, 9, 1'b1, 32'hDEAD0001, 1'b0);
        do_reset("rst_mid");
        lit = 128'h0000C003_0000C002_0000C001_0000C000;
        for (int w = 0; w < NW; w++) send(0, SEQ0 + w, 1'b1, 32'h0000C000 + 32'(w), 1'b0);
        pop_check(0, "mid_rec", got);
        check_word("mid_literal", got, lit);
        pop_check(0, "mid_extra", got);

        // Randomized records with noise and occasional duplicates.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NW; i++) ord[i] = i;
            for (int i = NW - 1; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(i, 0);
                t = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
            for (int i = 0; i < NW; i++) begin
                repeat ($urandom_range(2, 0)) send_noise(0);
                send(0, SEQ0 + ord[i], 1'b1, $urandom, 1'b0);
                if (i == 0 && $urandom_range(3, 0) == 0) send(0, SEQ0 + ord[0], 1'b1, $urandom, 1'b0);
            end
            pop_check(0, "rand", got);
            check_bit("rand_err", m_err, md_err[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
